app_1ch_behav: RTL and testbench

APP_1CH_BEHAV -- requirements
Module: app_1ch_behav

---
 rtl/app_1ch_behav.sv | 159 +++++++++++++++
 tb/tb_app_1ch_behav.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/app_1ch_behav.sv
// Single-channel photon detector model: LFSR hit source, threshold trigger, windowed
// integration and dead time. Optional pileup flag enabled by macro APP_PILEUP_FLAG_EN.
module app_1ch_behav #(
  parameter logic [8:0]  RATE         = 9'd16,
  parameter logic [7:0]  THRESH       = 8'd32,
  parameter int          INTEG_CYCLES = 8,
  parameter int          DEAD_CYCLES  = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_init,
  output logic        event_valid,
  output logic [15:0] event_time,
  output logic [11:0] event_amp,
  output logic [15:0] photon_count,
  output logic        pileup,
  output logic        busy
);

  localparam logic [15:0] SEED       = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  localparam logic [3:0]  INTEG_LAST = 4'(INTEG_CYCLES - 1);
  localparam logic [7:0]  DEAD_LEN   = (DEAD_CYCLES < 1) ? 8'd1 : 8'(DEAD_CYCLES);

  typedef enum logic [1:0] {IDLE, INTEG, DEAD} state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] ts;
  logic [15:0] lfsr;
  logic [15:0] pend_time;
  logic [15:0] fire_time;
  logic [12:0] acc;
  logic [12:0] acc_in;
  logic [13:0] acc_sum;
  logic [11:0] amp_sat;
  logic [3:0]  integ_cnt;
  logic [7:0]  dead_cnt;
  logic        hit;
  logic [7:0]  sample;
  logic        trigger;
  logic        start;
  logic        fire;

  assign hit       = ({1'b0, lfsr[7:0]} < RATE);
  assign sample    = hit ? lfsr[15:8] : 8'd0;
  assign trigger   = hit && (sample >= THRESH);
  // The trigger sample opens a fresh sum; later window cycles add onto acc.
  assign acc_in    = (state == IDLE) ? 13'd0 : acc;
  assign acc_sum   = {1'b0, acc_in} + {6'd0, sample};
  assign amp_sat   = (acc_sum > 14'd4095) ? 12'hFFF : acc_sum[11:0];
  assign fire_time = (state == IDLE) ? ts : pend_time;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst_init) begin
    if (rst_init) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DEAD opens with the event-presentation cycle, followed by the ignore window.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    fire       = 1'b0;
    unique case (state)
      IDLE: begin
        if (trigger) begin
          start = 1'b1;
          if (INTEG_CYCLES == 1) begin
            fire       = 1'b1;
            state_next = DEAD;
          end else begin
            state_next = INTEG;
          end
        end
      end
      INTEG: begin
        if (integ_cnt == INTEG_LAST) begin
          fire       = 1'b1;
          state_next = DEAD;
        end
      end
      DEAD: begin
        if (dead_cnt == DEAD_LEN) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_init) begin
    if (rst_init) begin
      ts           <= 16'd0;
      lfsr         <= SEED;
      pend_time    <= 16'd0;
      acc          <= 13'd0;
      integ_cnt    <= 4'd0;
      dead_cnt     <= 8'd0;
      event_valid  <= 1'b0;
      event_time   <= 16'd0;
      event_amp    <= 12'd0;
      photon_count <= 16'd0;
    end else begin
      ts          <= ts + 16'd1;
      lfsr        <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      event_valid <= fire;
      if (start) begin
        pend_time <= ts;
      end
      if (start || (state == INTEG)) begin
        acc <= acc_sum[12:0];
      end
      if (start) begin
        integ_cnt <= 4'd1;
      end else if (state == INTEG) begin
        integ_cnt <= integ_cnt + 4'd1;
      end
      if (fire) begin
        dead_cnt <= 8'd0;
      end else if (state == DEAD) begin
        dead_cnt <= dead_cnt + 8'd1;
      end
      if (fire) begin
        event_time <= fire_time;
        event_amp  <= amp_sat;
        if (photon_count != 16'hFFFF) begin
          photon_count <= photon_count + 16'd1;
        end
      end
    end
  end

`ifdef APP_PILEUP_FLAG_EN
  logic [4:0] hit_cnt;
  logic [4:0] hit_total;

  assign hit_total = (state == IDLE) ? 5'd1 : (hit_cnt + {4'd0, hit});

  always_ff @(posedge clk or posedge rst_init) begin
    if (rst_init) begin
      hit_cnt <= 5'd0;
      pileup  <= 1'b0;
    end else begin
      if (start || (state == INTEG)) begin
        hit_cnt <= hit_total;
      end
      if (fire) begin
        pileup <= (hit_total > 5'd1);
      end
    end
  end
`else
  assign pileup = 1'b0;
`endif

endmodule

// File: tb/tb_app_1ch_behav.sv
// Directed bench for app_1ch_behav: four configurations share one clock and reset,
// expectations come from an independent LFSR reference and hand-derived event timing.
module tb_app_1ch_behav;

`ifdef APP_PILEUP_FLAG_EN
  localparam logic PILEUP_EXP = 1'b1;
`else
  localparam logic PILEUP_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_init;

  always #5 clk = ~clk;

  logic        z_valid, m_valid, t_valid, l_valid;
  logic [15:0] z_time, m_time, t_time, l_time;
  logic [11:0] z_amp, m_amp, t_amp, l_amp;
  logic [15:0] z_count, m_count, t_count, l_count;
  logic        z_pileup, m_pileup, t_pileup, l_pileup;
  logic        z_busy, m_busy, t_busy, l_busy;

  app_1ch_behav #(.RATE(9'd0)) u_zero (
    .clk(clk), .rst_init(rst_init), .event_valid(z_valid), .event_time(z_time),
    .event_amp(z_amp), .photon_count(z_count), .pileup(z_pileup), .busy(z_busy));

  app_1ch_behav #(.RATE(9'd256), .THRESH(8'd0), .INTEG_CYCLES(4), .DEAD_CYCLES(2)) u_main (
    .clk(clk), .rst_init(rst_init), .event_valid(m_valid), .event_time(m_time),
    .event_amp(m_amp), .photon_count(m_count), .pileup(m_pileup), .busy(m_busy));

  app_1ch_behav #(.THRESH(8'd255)) u_thr (
    .clk(clk), .rst_init(rst_init), .event_valid(t_valid), .event_time(t_time),
    .event_amp(t_amp), .photon_count(t_count), .pileup(t_pileup), .busy(t_busy));

  app_1ch_behav #(.RATE(9'd256), .THRESH(8'd0), .INTEG_CYCLES(16)) u_long (
    .clk(clk), .rst_init(rst_init), .event_valid(l_valid), .event_time(l_time),
    .event_amp(l_amp), .photon_count(l_count), .pileup(l_pileup), .busy(l_busy));

  int checks = 0;
  int errors = 0;
  logic [15:0] lf [0:255];

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int unsigned main_amp;
    int unsigned long_amp;
    int          k;
    int          zero_bad;
    int          thr_pulses;
    int          thr_low;

    lf[0] = 16'hACE1;
    for (int i = 1; i < 256; i++) lf[i] = lfsr_next(lf[i-1]);
    long_amp = 0;
    for (int i = 0; i < 16; i++) long_amp += int'(lf[i][15:8]);
    zero_bad   = 0;
    thr_pulses = 0;
    thr_low    = 0;

    // 50 ns reset pulse
    rst_init = 1'b0;
    #2 rst_init = 1'b1;
    #40;
    check_output("rst_main_valid", 32'(m_valid), 32'd0);
    check_output("rst_main_count", 32'(m_count), 32'd0);
    check_output("rst_main_busy", 32'(m_busy), 32'd0);
    check_output("rst_main_ts", 32'(u_main.ts), 32'd0);
    check_output("rst_main_lfsr", 32'(u_main.lfsr), 32'hACE1);
    check_output("rst_main_pileup", 32'(m_pileup), 32'd0);
    #10 rst_init = 1'b0;

    for (int c = 1; c <= 66000; c++) begin
      @(posedge clk);
      #1;
      if ((z_valid !== 1'b0) || (z_busy !== 1'b0)) zero_bad++;
      if (t_valid === 1'b1) begin
        thr_pulses++;
        if (t_amp < 12'd255) thr_low++;
      end
      if (c < 200) begin
        check_output("main_busy", 32'(m_busy), 32'((c % 7) != 0));
        check_output("main_count", 32'(m_count), (c >= 4) ? 32'((c - 4) / 7 + 1) : 32'd0);
        check_output("main_pileup", 32'(m_pileup), (c >= 4) ? 32'(PILEUP_EXP) : 32'd0);
        if ((c >= 4) && (((c - 4) % 7) == 0)) begin
          k = (c - 4) / 7;
          main_amp = 0;
          for (int j = 0; j < 4; j++) main_amp += int'(lf[7*k+j][15:8]);
          check_output("main_valid", 32'(m_valid), 32'd1);
          check_output("main_time", 32'(m_time), 32'(7 * k));
          check_output("main_amp", 32'(m_amp), 32'(main_amp));
        end else begin
          check_output("main_valid_idle", 32'(m_valid), 32'd0);
        end
      end
      if (c == 4) check_output("main_amp_first", 32'(m_amp), 32'd567);
      if (c == 16) begin
        check_output("long_valid0", 32'(l_valid), 32'd1);
        check_output("long_time0", 32'(l_time), 32'd0);
        check_output("long_amp0", 32'(l_amp), 32'(long_amp));
      end
      if (c == 22) force u_long.acc = 13'h1000;
      if (c == 37) begin
        check_output("long_valid1", 32'(l_valid), 32'd1);
        check_output("long_time1", 32'(l_time), 32'd21);
        check_output("long_amp_sat", 32'(l_amp), 32'hFFF);
        check_output("long_count1", 32'(l_count), 32'd2);
        release u_long.acc;
      end
    end

    check_output("zero_never_active", 32'(zero_bad), 32'd0);
    check_output("zero_count", 32'(z_count), 32'd0);
    check_output("thr_amp_low_events", 32'(thr_low), 32'd0);
    check_output("thr_seen_event", 32'(thr_pulses > 0), 32'd1);
    check_output("thr_count_vs_pulses", 32'(t_count), 32'(thr_pulses));

    // Fresh start, then interrupt the second event while integrating
    rst_init = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_init = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      #1;
      if (c == 4) check_output("mid_first_valid", 32'(m_valid), 32'd1);
    end
    check_output("mid_busy_integ", 32'(m_busy), 32'd1);
    check_output("mid_count_before", 32'(m_count), 32'd1);
    check_output("mid_amp_before", 32'(m_amp), 32'd567);
    rst_init = 1'b1;
    #1;
    check_output("mid_rst_valid", 32'(m_valid), 32'd0);
    check_output("mid_rst_amp", 32'(m_amp), 32'd0);
    check_output("mid_rst_count", 32'(m_count), 32'd0);
    check_output("mid_rst_busy", 32'(m_busy), 32'd0);
    check_output("mid_rst_pileup", 32'(m_pileup), 32'd0);
    repeat (6) begin
      @(posedge clk);
      #1;
      check_output("mid_hold_valid", 32'(m_valid), 32'd0);
      check_output("mid_hold_count", 32'(m_count), 32'd0);
      check_output("mid_hold_ts", 32'(u_main.ts), 32'd0);
    end
    @(negedge clk) rst_init = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      check_output("post_rst_valid", 32'(m_valid), 32'(c == 4));
    end
    check_output("post_rst_time", 32'(m_time), 32'd0);
    check_output("post_rst_amp", 32'(m_amp), 32'd567);
    check_output("post_rst_count", 32'(m_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
